mmio_fifo_bank: RTL and testbench

Parametrised bank of MMIO-mapped FIFOs for CCI-P AFUs, replacing the single fixed 64-bit user FIFO with NUM_CH independent channels. Each channel exposes a push/pop data register and a status/control register. The AFU top decodes CCI-P c0 MMIO traffic into the flat request ports below, handles the DFH and AFU_ID registers itself, and forwards this block's read responses onto tx.c2.

---
 rtl/mmio_fifo_bank.sv | 138 +++++++++++++
 tb/tb_mmio_fifo_bank.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mmio_fifo_bank.sv
// Bank of NUM_CH independent MMIO-mapped FIFOs, each with DATA, STAT and optional PEEK registers.
// Define MMIO_FIFO_PEEK_EN to enable the non-popping PEEK register at offset +4.
module mmio_fifo_bank #(
  parameter int          NUM_CH    = 4,
  parameter int          DEPTH     = 16,
  parameter int          DATA_W    = 64,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_addr,
  input  logic [8:0]  mmio_tid,
  input  logic [63:0] mmio_wr_data,
  output logic        rd_rsp_valid,
  output logic [8:0]  rd_rsp_tid,
  output logic [63:0] rd_rsp_data
);
  localparam int          PTR_W    = $clog2(DEPTH);
  localparam int          CNT_W    = $clog2(DEPTH + 1);
  localparam int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] END_ADDR = 32'(BASE_ADDR) + 32'(8 * NUM_CH);

  typedef enum logic [2:0] {
    OFF_DATA = 3'd0,
    OFF_STAT = 3'd2,
    OFF_PEEK = 3'd4
  } reg_off_e;

  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [CNT_W-1:0]  count  [NUM_CH];
  logic              ovf    [NUM_CH];
  logic              udf    [NUM_CH];

  logic              in_range;
  logic [CH_W-1:0]   ch_sel;
  reg_off_e          off;
  logic              is_data, is_stat, is_peek;
  logic              wr_req, rd_req, rd_hit, push_en;
  logic              sel_full, sel_empty;
  logic [DATA_W-1:0] sel_head;
  logic [63:0]       rsp_word;
  logic              unused_wr_bits;

  // BASE_ADDR is 8-aligned, so the low address bits are the register offset.
  assign in_range  = (mmio_addr >= BASE_ADDR) && (32'(mmio_addr) < END_ADDR);
  assign ch_sel    = CH_W'((mmio_addr - BASE_ADDR) >> 3);
  assign off       = reg_off_e'(mmio_addr[2:0]);
  assign is_data   = (off == OFF_DATA);
  assign is_stat   = (off == OFF_STAT);
`ifdef MMIO_FIFO_PEEK_EN
  assign is_peek   = (off == OFF_PEEK);
`else
  assign is_peek   = 1'b0;
`endif

  // A simultaneous write wins; the read is dropped without a response.
  assign wr_req    = mmio_wr_valid && in_range;
  assign rd_req    = mmio_rd_valid && !mmio_wr_valid && in_range;
  assign rd_hit    = rd_req && (is_data || is_stat || is_peek);

  assign sel_full  = (count[ch_sel] == CNT_W'(DEPTH));
  assign sel_empty = (count[ch_sel] == '0);
  assign sel_head  = mem[ch_sel][rd_ptr[ch_sel]];
  assign push_en   = wr_req && is_data && !sel_full;

  assign unused_wr_bits = ^mmio_wr_data;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rsp_word = 64'h0;
    if (is_stat)
      rsp_word = {16'(count[ch_sel]), 44'h0, udf[ch_sel], ovf[ch_sel], sel_full, sel_empty};
    else if (!sel_empty)
      rsp_word = 64'(sel_head);
  end

  // NOTE: storage has no reset; only pointers/counts/flags define validity, so the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push_en)
      mem[ch_sel][wr_ptr[ch_sel]] <= mmio_wr_data[DATA_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_tid   <= '0;
      rd_rsp_data  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
        ovf[i]    <= 1'b0;
        udf[i]    <= 1'b0;
      end
    end else begin
      rd_rsp_valid <= rd_hit;
      if (rd_hit) begin
        rd_rsp_tid  <= mmio_tid;
        rd_rsp_data <= rsp_word;
      end

      if (wr_req && is_data) begin
        if (sel_full) begin
          ovf[ch_sel] <= 1'b1;
        end else begin
          wr_ptr[ch_sel] <= wr_ptr[ch_sel] + PTR_W'(1);
          count[ch_sel]  <= count[ch_sel] + CNT_W'(1);
        end
      end

      if (wr_req && is_stat) begin
        if (mmio_wr_data[0]) begin
          ovf[ch_sel] <= 1'b0;
          udf[ch_sel] <= 1'b0;
        end
        if (mmio_wr_data[1]) begin
          rd_ptr[ch_sel] <= '0;
          wr_ptr[ch_sel] <= '0;
          count[ch_sel]  <= '0;
        end
      end

      if (rd_req && is_data) begin
        if (sel_empty) begin
          udf[ch_sel] <= 1'b1;
        end else begin
          rd_ptr[ch_sel] <= rd_ptr[ch_sel] + PTR_W'(1);
          count[ch_sel]  <= count[ch_sel] - CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_mmio_fifo_bank.sv
// Directed bench for mmio_fifo_bank: a default instance and a DATA_W=32 instance share all inputs.
module tb_mmio_fifo_bank;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmio_wr_valid = 1'b0;
  logic        mmio_rd_valid = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [8:0]  mmio_tid = '0;
  logic [63:0] mmio_wr_data = '0;
  logic        rd_rsp_valid, rsp32_valid;
  logic [8:0]  rd_rsp_tid, rsp32_tid;
  logic [63:0] rd_rsp_data, rsp32_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] next_tid = 9'h100;

  always #5 clk = ~clk;

  mmio_fifo_bank dut (
    .clk(clk), .rst(rst), .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_tid(rd_rsp_tid), .rd_rsp_data(rd_rsp_data)
  );

  mmio_fifo_bank #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst), .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
    .rd_rsp_valid(rsp32_valid), .rd_rsp_tid(rsp32_tid), .rd_rsp_data(rsp32_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_wr(input logic [15:0] addr, input logic [63:0] data);
    mmio_wr_valid = 1'b1;
    mmio_addr     = addr;
    mmio_wr_data  = data;
    tick();
    mmio_wr_valid = 1'b0;
  endtask

  // Issues one read cycle; consecutive calls produce back-to-back requests.
  task automatic rd_check(input string tag, input logic [15:0] addr,
                          input logic [63:0] exp, input logic [63:0] exp32);
    logic [8:0] t;
    t = next_tid;
    next_tid = next_tid + 9'd7;
    mmio_rd_valid = 1'b1;
    mmio_addr     = addr;
    mmio_tid      = t;
    tick();
    mmio_rd_valid = 1'b0;
    check({tag, ".valid"}, 64'(rd_rsp_valid), 64'h1);
    check({tag, ".tid"},   64'(rd_rsp_tid), 64'(t));
    check({tag, ".data"},  rd_rsp_data, exp);
    check({tag, ".data32"}, rsp32_data, exp32);
  endtask

  task automatic rd_none(input string tag, input logic [15:0] addr);
    mmio_rd_valid = 1'b1;
    mmio_addr     = addr;
    tick();
    mmio_rd_valid = 1'b0;
    check({tag, ".novalid"}, 64'({rd_rsp_valid, rsp32_valid}), 64'h0);
  endtask

  initial begin
    repeat (3) tick();
    check("reset.valid", 64'(rd_rsp_valid), 64'h0);
    check("reset.tid",   64'(rd_rsp_tid), 64'h0);
    check("reset.data",  rd_rsp_data, 64'h0);
    rst = 1'b0;
    tick();

    rd_check("stat0_empty", 16'h0022, 64'h1, 64'h1);
    tick();
    check("pulse_one_cycle", 64'(rd_rsp_valid), 64'h0);

    mmio_wr(16'h0030, 64'hA1);
    mmio_wr(16'h0030, 64'hA2);
    mmio_wr(16'h0030, 64'hA3);
    rd_check("ch2_pop1", 16'h0030, 64'hA1, 64'hA1);
    rd_check("ch2_pop2", 16'h0030, 64'hA2, 64'hA2);
    rd_check("ch2_pop3", 16'h0030, 64'hA3, 64'hA3);
    rd_check("ch2_underrun", 16'h0030, 64'h0, 64'h0);
    rd_check("ch2_stat_udf", 16'h0032, 64'h9, 64'h9);

    for (int k = 1; k <= 17; k++) mmio_wr(16'h0028, 64'hAB00_0000_0000_0000 + 64'(k));
    rd_check("ch1_full_stat", 16'h002A, 64'h0010_0000_0000_0006, 64'h0010_0000_0000_0006);
    for (int k = 1; k <= 16; k++)
      rd_check($sformatf("ch1_drain%0d", k), 16'h0028, 64'hAB00_0000_0000_0000 + 64'(k), 64'(k));
    rd_check("ch1_drained_stat", 16'h002A, 64'h5, 64'h5);
    mmio_wr(16'h0028, 64'h55);
    rd_check("ch1_wrap", 16'h0028, 64'h55, 64'h55);

    mmio_wr(16'h0020, 64'hDEAD_BEEF_1234_5678);
    rd_check("ch0_width", 16'h0020, 64'hDEAD_BEEF_1234_5678, 64'h0000_0000_1234_5678);

    mmio_wr(16'h0028, 64'h11);
    mmio_wr(16'h0028, 64'h22);
    for (int k = 0; k < 17; k++) mmio_wr(16'h0038, 64'(k));
    rd_check("ch3_full_stat", 16'h003A, 64'h0010_0000_0000_0006, 64'h0010_0000_0000_0006);
    mmio_wr(16'h003A, 64'h3);
    rd_check("ch3_flush_clear", 16'h003A, 64'h1, 64'h1);
    rd_check("ch1_untouched", 16'h002A, 64'h0002_0000_0000_0004, 64'h0002_0000_0000_0004);
    mmio_wr(16'h002A, 64'h1);
    rd_check("ch1_clear_only", 16'h002A, 64'h0002_0000_0000_0000, 64'h0002_0000_0000_0000);
    rd_check("ch1_head_kept", 16'h0028, 64'h11, 64'h11);

    rd_none("miss_high", 16'h0040);
    rd_none("miss_low", 16'h001F);
    rd_none("miss_off1", 16'h0021);
    mmio_wr(16'h0040, 64'hFF);
    mmio_wr(16'h0021, 64'hFF);
    rd_check("ch0_after_miss_wr", 16'h0022, 64'h1, 64'h1);

    mmio_wr_valid = 1'b1;
    mmio_rd_valid = 1'b1;
    mmio_addr     = 16'h0020;
    mmio_wr_data  = 64'h5A;
    tick();
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    check("wr_rd_collide.novalid", 64'(rd_rsp_valid), 64'h0);
    rd_check("wr_rd_collide.data", 16'h0020, 64'h5A, 64'h5A);

`ifdef MMIO_FIFO_PEEK_EN
    mmio_wr(16'h0020, 64'h99);
    mmio_wr(16'h0020, 64'h9A);
    rd_check("peek1", 16'h0024, 64'h99, 64'h99);
    rd_check("peek2", 16'h0024, 64'h99, 64'h99);
    rd_check("peek_count", 16'h0022, 64'h0002_0000_0000_0000, 64'h0002_0000_0000_0000);
    mmio_wr(16'h0024, 64'h77);
    rd_check("peek_wr_ignored", 16'h0022, 64'h0002_0000_0000_0000, 64'h0002_0000_0000_0000);
`else
    rd_none("peek_disabled", 16'h0024);
`endif

    mmio_wr(16'h0020, 64'h77);
    mmio_rd_valid = 1'b1;
    mmio_addr     = 16'h0020;
    tick();
    mmio_rd_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_cancel.valid", 64'(rd_rsp_valid), 64'h0);
    check("rst_cancel.data",  rd_rsp_data, 64'h0);
    mmio_rd_valid = 1'b1;
    mmio_addr     = 16'h0022;
    tick();
    mmio_rd_valid = 1'b0;
    check("rst_priority.valid", 64'(rd_rsp_valid), 64'h0);
    rst = 1'b0;
    rd_check("rst_ch2_flags", 16'h0032, 64'h1, 64'h1);
    rd_check("rst_ch3_empty", 16'h003A, 64'h1, 64'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
